// File: rtl/switch_sequencer.sv
// Programmable 16-step voice-mask sequencer driving the sound card's 4-bit switches input.
// Each step holds a mask for len tempo ticks; a len=0 entry marks the end of the pattern.
module switch_sequencer #(
   parameter int unsigned TICK_DIV = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [3:0] wr_mask,
   input  logic [3:0] wr_len,
   input  logic       start,
   input  logic       stop,
   input  logic       loop,
   output logic [3:0] switches,
   output logic [3:0] step,
   output logic       playing,
   output logic       done
);

   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StPlay, StDone} state_e;

   state_e           state_q, state_d;
   logic [3:0]       step_q, step_d;
   logic [3:0]       rem_q, rem_d;
   logic [TickW-1:0] tick_q, tick_d;
   logic [3:0]       switches_q, switches_d;
   logic             playing_q, playing_d;
   logic             done_q, done_d;

   logic [7:0]       mem_q [16];
   logic [7:0]       mem_d [16];
   logic [3:0]       rd_mask;
   logic [3:0]       rd_len;

   assign {rd_mask, rd_len} = mem_q[step_q];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = {wr_mask, wr_len};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      rem_d      = rem_q;
      tick_d     = tick_q;
      switches_d = switches_q;

      if (stop && (state_q != StIdle)) begin
         state_d    = StIdle;
         switches_d = 4'h0;
      end else if (start && (state_q != StDone)) begin
         // Restart keeps the current mask on the outputs until the new LOAD resolves.
         state_d = StLoad;
         step_d  = 4'h0;
      end else begin
         case (state_q)
            StIdle: begin
               switches_d = 4'h0;
            end
            StLoad: begin
               if (rd_len != 4'h0) begin
                  switches_d = rd_mask;
                  rem_d      = rd_len;
                  tick_d     = '0;
                  state_d    = StPlay;
               end else if (loop && (step_q != 4'h0)) begin
                  step_d = 4'h0;
               end else begin
                  state_d    = StDone;
                  switches_d = 4'h0;
               end
            end
            StPlay: begin
               if (tick_q == TickLast) begin
                  tick_d = '0;
                  rem_d  = rem_q - 4'h1;
                  if (rem_q == 4'h1) begin
                     if (step_q != 4'hf) begin
                        step_d  = step_q + 4'h1;
                        state_d = StLoad;
                     end else if (loop) begin
                        step_d  = 4'h0;
                        state_d = StLoad;
                     end else begin
                        state_d    = StDone;
                        switches_d = 4'h0;
                     end
                  end
               end else begin
                  tick_d = tick_q + TickW'(1);
               end
            end
            StDone: begin
               state_d    = StIdle;
               switches_d = 4'h0;
            end
            default: begin
               state_d    = StIdle;
               switches_d = 4'h0;
            end
         endcase
      end

      // Status flags are registered copies of the next state so they align with it.
      playing_d = (state_d == StLoad) || (state_d == StPlay);
      done_d    = (state_d == StDone);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         step_q     <= 4'h0;
         rem_q      <= 4'h0;
         tick_q     <= '0;
         switches_q <= 4'h0;
         playing_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         rem_q      <= rem_d;
         tick_q     <= tick_d;
         switches_q <= switches_d;
         playing_q  <= playing_d;
         done_q     <= done_d;
      end
   end

   assign switches = switches_q;
   assign step     = step_q;
   assign playing  = playing_q;
   assign done     = done_q;

endmodule

// File: tb/tb_switch_sequencer.sv
// Directed bench for switch_sequencer with TICK_DIV=4: per-cycle vector tables for the
// basic and looping pattern, plus hand sequences for reset, stop, wrap and live writes.
module tb_switch_sequencer;

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [3:0] wr_mask;
   logic [3:0] wr_len;
   logic       start;
   logic       stop;
   logic       loop;
   logic [3:0] switches;
   logic [3:0] step;
   logic       playing;
   logic       done;

   int unsigned n_vec;
   int unsigned n_err;

   switch_sequencer #(
      .TICK_DIV (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_mask  (wr_mask),
      .wr_len   (wr_len),
      .start    (start),
      .stop     (stop),
      .loop     (loop),
      .switches (switches),
      .step     (step),
      .playing  (playing),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are applied for rep cycles; outputs are checked after each of those edges.
   typedef struct {
      logic        st;
      logic        sp;
      logic        lp;
      int unsigned rep;
      logic [3:0]  sw;
      logic [3:0]  stp;
      logic        ply;
      logic        dn;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic st, input logic sp, input logic lp,
                               input int unsigned rep, input logic [3:0] sw,
                               input logic [3:0] stp, input logic ply, input logic dn);
      vec_t v;
      v.st  = st;
      v.sp  = sp;
      v.lp  = lp;
      v.rep = rep;
      v.sw  = sw;
      v.stp = stp;
      v.ply = ply;
      v.dn  = dn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] m, input logic [3:0] l);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_mask = m;
      wr_len  = l;
      cyc(1);
      wr_en   = 1'b0;
   endtask

   task automatic run_tbl(input int first, input int last);
      for (int i = first; i < last; i++) begin
         for (int r = 0; r < int'(tbl[i].rep); r++) begin
            start = tbl[i].st;
            stop  = tbl[i].sp;
            loop  = tbl[i].lp;
            cyc(1);
            chk($sformatf("tbl[%0d].%0d sw/step/play/done", i, r),
                {6'h0, switches, step, playing, done},
                {6'h0, tbl[i].sw, tbl[i].stp, tbl[i].ply, tbl[i].dn});
         end
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   initial begin
      int basic_end;
      int loop_end;
      logic quiet;

      // Basic pattern {0001,2},{0010,1},{0100,3},{1000,0}, loop=0.
      tbl.push_back(mk(1, 0, 0, 1,  4'h0, 4'h0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8,  4'h1, 4'h0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  4'h1, 4'h1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 4,  4'h2, 4'h1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  4'h2, 4'h2, 1, 0));
      tbl.push_back(mk(0, 0, 0, 12, 4'h4, 4'h2, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  4'h4, 4'h3, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  4'h0, 4'h3, 0, 1));
      tbl.push_back(mk(0, 0, 0, 2,  4'h0, 4'h3, 0, 0));
      basic_end = tbl.size();
      // Same pattern looping once, then loop dropped before the second marker.
      tbl.push_back(mk(1, 0, 1, 1,  4'h0, 4'h0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 8,  4'h1, 4'h0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1,  4'h1, 4'h1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 4,  4'h2, 4'h1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1,  4'h2, 4'h2, 1, 0));
      tbl.push_back(mk(0, 0, 1, 12, 4'h4, 4'h2, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1,  4'h4, 4'h3, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1,  4'h4, 4'h0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 8,  4'h1, 4'h0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  4'h1, 4'h1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 4,  4'h2, 4'h1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  4'h2, 4'h2, 1, 0));
      tbl.push_back(mk(0, 0, 0, 12, 4'h4, 4'h2, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  4'h4, 4'h3, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  4'h0, 4'h3, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1,  4'h0, 4'h3, 0, 0));
      loop_end = tbl.size();

      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_addr = 4'h0;
      wr_mask = 4'h0;
      wr_len  = 4'h0;
      start   = 1'b0;
      stop    = 1'b0;
      loop    = 1'b0;
      cyc(2);
      reset = 1'b0;
      cyc(1);
      chk("reset defaults", {6'h0, switches, step, playing, done}, 16'h0);

      wr(4'h0, 4'h1, 4'h2);
      wr(4'h1, 4'h2, 4'h1);
      wr(4'h2, 4'h4, 4'h3);
      wr(4'h3, 4'h8, 4'h0);
      run_tbl(0, basic_end);
      run_tbl(basic_end, loop_end);

      // Stop beats start mid-PLAY; nothing plays afterwards and done never fires.
      pulse_start();
      cyc(3);
      chk("pre-stop sw", {12'h0, switches}, 16'h1);
      start = 1'b1;
      stop  = 1'b1;
      cyc(1);
      start = 1'b0;
      stop  = 1'b0;
      chk("stop sw/play/done", {12'h0, switches, playing, done}, 16'h0);
      quiet = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (done || playing || (switches != 4'h0)) quiet = 1'b0;
      end
      chk("stop stays idle", {15'h0, quiet}, 16'h1);

      // Asynchronous reset mid-playback, then start on the erased memory.
      pulse_start();
      cyc(3);
      chk("pre-reset play", {11'h0, switches, playing}, {11'h0, 4'h1, 1'b1});
      #2 reset = 1'b1;
      #1 chk("async reset sw/play/done", {10'h0, switches, playing, done}, 16'h0);
      @(negedge clk);
      reset = 1'b0;
      pulse_start();
      chk("empty LOAD", {12'h0, switches, playing, done}, {10'h0, 4'h0, 1'b1, 1'b0});
      cyc(1);
      chk("empty DONE", {12'h0, switches, playing, done}, {10'h0, 4'h0, 1'b0, 1'b1});
      cyc(1);
      chk("empty IDLE", {12'h0, switches, playing, done}, 16'h0);

      // Full 16-step pattern, each len=1 with mask equal to its index.
      for (int k = 0; k < 16; k++) begin
         wr(4'(k), 4'(k), 4'h1);
      end
      loop = 1'b0;
      pulse_start();
      for (int k = 0; k < 16; k++) begin
         for (int i = 1; i <= ((k == 15) ? 4 : 5); i++) begin
            cyc(1);
            chk($sformatf("wrap k%0d c%0d", k, i), {8'h0, switches, step},
                {8'h0, 4'(k), (i == 5) ? 4'(k + 1) : 4'(k)});
         end
      end
      cyc(1);
      chk("wrap done", {8'h0, switches, step, playing, done},
          {8'h0, 4'h0, 4'hf, 1'b0, 1'b1});
      cyc(2);

      loop = 1'b1;
      pulse_start();
      cyc(80);
      chk("wrap15->0 LOAD", {7'h0, switches, step, playing}, {7'h0, 4'hf, 4'h0, 1'b1});
      cyc(6);
      chk("wrap second pass", {8'h0, switches, step}, {8'h0, 4'h1, 4'h1});
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      chk("wrap stop", {11'h0, switches, playing}, 16'h0);

      // Live write of the playing step appears only on the next pass.
      wr(4'h0, 4'h1, 4'h2);
      wr(4'h1, 4'h2, 4'h1);
      wr(4'h2, 4'h4, 4'h3);
      wr(4'h3, 4'h8, 4'h0);
      loop = 1'b1;
      pulse_start();
      cyc(10);
      chk("live step1", {8'h0, switches, step}, {8'h0, 4'h2, 4'h1});
      wr(4'h1, 4'hf, 4'h1);
      chk("live after write", {12'h0, switches}, 16'h2);
      cyc(3);
      chk("live load2", {8'h0, switches, step}, {8'h0, 4'h2, 4'h2});
      cyc(1);
      chk("live step2", {12'h0, switches}, 16'h4);
      cyc(23);
      chk("live new mask", {8'h0, switches, step}, {8'h0, 4'hf, 4'h1});
      cyc(5);
      chk("live next step", {12'h0, switches}, 16'h4);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      loop = 1'b0;
      chk("live stop", {11'h0, switches, playing}, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
